// File: rtl/uart_byte_tx_if.sv
// -----------------------------------------------------------------------------
// uart_byte_tx_if
//   Request / line bundle for the UART byte transmitter.
//
//   Signals:
//     data_byte  [7:0]  byte to send, sampled on an accepted send_en
//     send_en           one-cycle transmit request
//     baud_set   [2:0]  rate select, sampled together with data_byte
//     Rs232_Tx          serial line, idle high
//     Tx_Done           one-cycle pulse when a frame completes
//     uart_state        high while a frame is in progress
//
//   Modports:
//     master  - the requester (drives data/request, observes line/status)
//     slave   - the transmitter (uart_byte_tx)
// -----------------------------------------------------------------------------
interface uart_byte_tx_if;
  logic [7:0] data_byte;
  logic       send_en;
  logic [2:0] baud_set;
  logic       Rs232_Tx;
  logic       Tx_Done;
  logic       uart_state;

  modport master (
    output data_byte, send_en, baud_set,
    input  Rs232_Tx, Tx_Done, uart_state
  );

  modport slave (
    input  data_byte, send_en, baud_set,
    output Rs232_Tx, Tx_Done, uart_state
  );
endinterface

// File: rtl/uart_byte_tx.sv
// -----------------------------------------------------------------------------
// uart_byte_tx
//   UART byte transmitter. Serialises one byte per accepted request as
//   start(0), D0..D7 (LSB first), optional even parity, stop(1). Each bit is
//   held for N = CLK_FREQ/baud clock cycles.
//
//   Parameters:
//     CLK_FREQ  system clock frequency in Hz (bit periods derive from it)
//
//   Ports:
//     Clk    system clock, rising edge
//     Rst_n  asynchronous active-low reset
//     tx     uart_byte_tx_if.slave (data_byte, send_en, baud_set in;
//            Rs232_Tx, Tx_Done, uart_state out)
//
//   Optional feature:
//     UART_TX_PARITY_EN - when defined, an even-parity bit (XOR of D0..D7)
//                         is sent between D7 and the stop bit (11-bit frame).
// -----------------------------------------------------------------------------
module uart_byte_tx #(
  parameter int CLK_FREQ = 50000000
) (
  input  logic          Clk,
  input  logic          Rst_n,
  uart_byte_tx_if.slave tx
);

  // The slowest rate (9600) gives the largest divider terminal count.
  localparam int N_MAX = CLK_FREQ / 9600;
  localparam int DIV_W = (N_MAX > 2) ? $clog2(N_MAX) : 1;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  // Bits that follow the start bit: data (+ parity) + stop.
  localparam int PAY_W = FRAME_BITS - 1;
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  // Divider terminal counts (N-1) for each rate.
  localparam logic [DIV_W-1:0] LIM_9600   = DIV_W'(CLK_FREQ / 9600 - 1);
  localparam logic [DIV_W-1:0] LIM_19200  = DIV_W'(CLK_FREQ / 19200 - 1);
  localparam logic [DIV_W-1:0] LIM_38400  = DIV_W'(CLK_FREQ / 38400 - 1);
  localparam logic [DIV_W-1:0] LIM_57600  = DIV_W'(CLK_FREQ / 57600 - 1);
  localparam logic [DIV_W-1:0] LIM_115200 = DIV_W'(CLK_FREQ / 115200 - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;      // cycles elapsed within current bit
  logic [DIV_W-1:0]   lim_q, lim_d;      // latched N-1 for the frame's rate
  logic [3:0]         bit_q, bit_d;      // index of bit currently on the line
  logic [PAY_W-1:0]   shreg_q, shreg_d;  // remaining bits, next one in [0]
  logic               tx_q, tx_d;
  logic               done_q, done_d;

  function automatic logic [DIV_W-1:0] baud_limit(input logic [2:0] sel);
    case (sel)
      3'd1:    return LIM_19200;
      3'd2:    return LIM_38400;
      3'd3:    return LIM_57600;
      3'd4:    return LIM_115200;
      default: return LIM_9600;   // 0 and the unused codes 5..7
    endcase
  endfunction

  // Everything sent after the start bit, LSB first; stop bit ends up last.
  function automatic logic [PAY_W-1:0] payload(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d};
`else
    return {1'b1, d};
`endif
  endfunction

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      lim_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      lim_q   <= lim_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    lim_d   = lim_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        // The Tx_Done cycle is already IDLE, so a request there starts the
        // next frame without any extra gap.
        if (tx.send_en) begin
          state_d = SEND;
          lim_d   = baud_limit(tx.baud_set);
          shreg_d = payload(tx.data_byte);
          div_d   = '0;
          bit_d   = '0;
          tx_d    = 1'b0;             // start bit
        end
      end

      SEND: begin
        // Inputs are deliberately not looked at here: requests and input
        // changes during a frame have no effect.
        if (div_q == lim_q) begin
          div_d = '0;
          if (bit_q == LAST_BIT) begin
            state_d = IDLE;
            tx_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            bit_d   = bit_q + 4'd1;
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign tx.Rs232_Tx   = tx_q;
  assign tx.Tx_Done    = done_q;
  assign tx.uart_state = (state_q == SEND);

endmodule
